mmio_timer_periph: RTL and testbench
====================================

Name: mmio_timer_periph

Overview:
- Memory-mapped peripheral block downstream of the multi-cycle CPU's shared memory port; consumes the same Address/Write_data/MemRead/MemWrite the CPU drives into instruction/data memory.
- Decodes a 32-byte peripheral window and provides:
  - a reloadable 32-bit timer with interrupt flag
  - an LED register
  - a 7-segment digit register
  - a free-running systick counter.
- The top level muxes Read_data over memory data when hit=1.

Parameters:
BASE_ADDR, 32'h4000_0000, byte base of the peripheral window (32-byte aligned)
PRESCALE, 1, clk cycles per timer tick (>=1; 1 = tick every cycle)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
Address  in  32  byte address from CPU memory mux
Write_data  in  32  store data (CPU B register)
MemRead  in  1  read strobe
MemWrite  in  1  write strobe
Read_data  out  32  register read data; combinational
hit  out  1  Address inside window (Address[31:5]==BASE_ADDR[31:5])
irq  out  1  TCON[2] & TCON[1]
led  out  8  LED register
digi  out  12  7-seg register {AN[3:0], SEG[7:0]}

Behaviour:
- Register map, word offset Address[4:2]; Address[1:0] ignored:
  - 0 TH (reload value)
  - 1 TL (counter)
  - 2 TCON: bit0 enable, bit1 irq_en, bit2 irq_flag; bits 31:3 read 0
  - 3 LED[7:0]
  - 4 DIGI[11:0]
  - 5 SYSTICK, read-only
  - 6-7 reserved: read 0, writes ignored
- Reset (reset=0, async): TH=TL=TCON=LED=DIGI=SYSTICK=0, prescale counter=0. Outputs: Read_data=0, irq=0, led=0, digi=0.
- Read: Read_data = selected register when hit & MemRead, else 32'h0. Zero latency, same cycle as Address.
- Write: on clk edge when hit & MemWrite; fields narrower than 32 take low bits. Writes to SYSTICK/reserved are ignored.
- Prescaler: counts 0..PRESCALE-1 while TCON[0]=1. tick=1 in the cycle the count is PRESCALE-1, then it wraps to 0. Holds its value while TCON[0]=0.
- Timer, on each tick with TCON[0]=1:
  - TL!=32'hFFFF_FFFF: TL<=TL+1.
  - TL==32'hFFFF_FFFF: TL<=TH; if TCON[1], TCON[2]<=1.
- SYSTICK: +1 every clk, unconditionally; wraps FFFF_FFFF->0.
- Simultaneous events:
  - CPU write to TL in the same cycle as increment/reload: CPU write wins.
  - CPU write to TCON in the same cycle as hardware flag set: bits 1:0 take written value; bit2 = 1 (hardware set wins, so the interrupt is never lost).
  - Write TCON[0]=0 on a tick cycle: that tick still applies this cycle, and the timer stops from the next cycle.
- irq: combinational from TCON. It stays high until software clears bit2 (write 0) or clears irq_en.
- Reset asserted mid-count: all state is cleared immediately. Counting resumes only after software sets TCON[0].

Decomposition:
- Shared package mmio_pkg holds:
  - word-offset constants OFF_TH=0, OFF_TL=1, OFF_TCON=2, OFF_LED=3, OFF_DIGI=4, OFF_SYSTICK=5
  - TCON bit indices TCON_EN=0, TCON_IE=1, TCON_IF=2.
- One sub-module mmio_timer (prescaler, TH/TL/TCON, irq) with write-enable/data inputs.
- The top handles decode, LED/DIGI/SYSTICK and the read mux.

Test Plan:
1. Release reset -> all outputs 0. Read 0x4000_0014 after 10 cycles -> 10 (±1 per bench sampling convention, documented in bench).
2. Write TH=FFFF_FFF0, TL=FFFF_FFFE, TCON=3, PRESCALE=1 -> TL reads FFFF_FFFF next tick. The following tick gives TL=FFFF_FFF0, TCON=7, irq=1.
3. With irq=1, write TCON=3 -> irq=0 next cycle. Same write landing on an overflow cycle -> TCON reads 7, irq remains 1.
4. PRESCALE=4, TCON=1, TL=0 -> TL=1 after 4 cycles, 5 after 20. Write TCON=0 -> TL frozen across 50 cycles.
5. Write LED=0x1A5 -> led=8'hA5. Write DIGI=0xFFF_F123 -> digi=12'h123. Read 0x4000_001C -> 0. Address 0x4000_0020 -> hit=0, Read_data=0, no state change.
6. Assert reset mid-count (TL=0x100, TCON=7) -> TL, TCON, irq are 0 immediately. After release, TL stays 0 until TCON[0] is written.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: register word offsets and TCON bit positions shared by the timer peripheral.
package mmio_pkg;
  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_DIGI    = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IF = 2;
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: prescaled reloadable 32-bit up-counter with sticky overflow flag and irq.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_th,
  input  logic        we_tl,
  input  logic        we_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);
  localparam logic [31:0] PMAX = 32'(PRESCALE - 1);
  logic [31:0] pcnt;
  logic        tick, ovf, set_if;
  assign tick   = tcon[TCON_EN] && pcnt == PMAX;
  assign ovf    = tick && &tl;
  assign set_if = ovf && tcon[TCON_IE];
  assign irq    = tcon[TCON_IF] & tcon[TCON_IE];
  // A hardware flag set is ORed into a same-cycle TCON write so the interrupt is never lost.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pcnt <= '0;
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (tcon[TCON_EN]) pcnt <= tick ? '0 : pcnt + 32'd1;
      if (we_th) th <= wdata;
      tl   <= we_tl ? wdata : ovf ? th : tick ? tl + 32'd1 : tl;
      tcon <= we_tcon ? {wdata[2] | set_if, wdata[1:0]} : tcon | {set_if, 2'b00};
    end
endmodule

// File: rtl/mmio_timer_periph.sv
// mmio_timer_periph: 32-byte MMIO window with timer, LED, 7-seg and systick registers.
module mmio_timer_periph
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        hit,
  output logic        irq,
  output logic [7:0]  led,
  output logic [11:0] digi
);
  logic [2:0]  off, tcon;
  logic [31:0] th, tl, systick;
  logic        wr, unused_addr;
  assign hit         = Address[31:5] == BASE_ADDR[31:5];
  assign off         = Address[4:2];
  assign wr          = hit & MemWrite;
  assign unused_addr = ^Address[1:0];
  mmio_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .we_th   (wr && off == OFF_TH),
    .we_tl   (wr && off == OFF_TL),
    .we_tcon (wr && off == OFF_TCON),
    .wdata   (Write_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (wr && off == OFF_LED) led <= Write_data[7:0];
      if (wr && off == OFF_DIGI) digi <= Write_data[11:0];
    end
  always_comb
    Read_data = !(hit && MemRead)  ? 32'h0 :
                off == OFF_TH      ? th :
                off == OFF_TL      ? tl :
                off == OFF_TCON    ? {29'h0, tcon} :
                off == OFF_LED     ? {24'h0, led} :
                off == OFF_DIGI    ? {20'h0, digi} :
                off == OFF_SYSTICK ? systick : 32'h0;
endmodule

// File: tb/tb_mmio_timer_periph.sv
// tb_mmio_timer_periph: directed tables, corner sequences and random traffic vs. a register-level model.
module tb_mmio_timer_periph;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic        clk = 0, reset = 0, re = 0, we = 0;
  logic [31:0] addr = 0, wd = 0, rd1, rd4;
  logic        hit1, hit4, irq1, irq4;
  logic [7:0]  led1, led4;
  logic [11:0] digi1, digi4;
  always #5 clk = ~clk;
  mmio_timer_periph #(.BASE_ADDR(BASE), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .Address(addr), .Write_data(wd), .MemRead(re), .MemWrite(we),
    .Read_data(rd1), .hit(hit1), .irq(irq1), .led(led1), .digi(digi1));
  mmio_timer_periph #(.BASE_ADDR(BASE), .PRESCALE(4)) u4 (
    .clk(clk), .reset(reset), .Address(addr), .Write_data(wd), .MemRead(re), .MemWrite(we),
    .Read_data(rd4), .hit(hit4), .irq(irq4), .led(led4), .digi(digi4));
  typedef struct {
    logic [31:0] th, tl, systick;
    logic [2:0]  tcon;
    logic [7:0]  led;
    logic [11:0] digi;
    int          phase;
  } mdl_t;
  typedef struct {
    logic [31:0] a, d;
    logic        w, r;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;
  mdl_t        m1, m4;
  int          nerr = 0, nchk = 0;
  logic [31:0] c_rd1, c_rd4, e_rd1, e_rd4;
  logic        c_hit, c_hit4, e_hit, c_irq1, c_irq4, e_irq1, e_irq4;
  logic [7:0]  c_led, e_led;
  logic [11:0] c_digi, e_digi;
  vec_t        tbl[14];
  function automatic logic in_win(logic [31:0] a);
    return (a >> 5) == (BASE >> 5);
  endfunction
  // Timer ticks when the cycle count since enable reaches a multiple of ps.
  function automatic mdl_t step(mdl_t m, int ps, logic [31:0] a, logic [31:0] d, logic w);
    mdl_t n = m;
    logic tick, hw;
    tick = m.tcon[0] && m.phase == ps - 1;
    hw = tick && m.tl == 32'hFFFF_FFFF && m.tcon[1];
    n.systick = m.systick + 1;
    if (m.tcon[0]) n.phase = (m.phase + 1) % ps;
    if (tick) n.tl = (m.tl == 32'hFFFF_FFFF) ? m.th : m.tl + 1;
    if (hw) n.tcon[2] = 1'b1;
    if (w && in_win(a))
      case (a[4:2])
        3'd0: n.th = d;
        3'd1: n.tl = d;
        3'd2: n.tcon = {d[2] | hw, d[1:0]};
        3'd3: n.led = d[7:0];
        3'd4: n.digi = d[11:0];
        default: ;
      endcase
    return n;
  endfunction
  function automatic logic [31:0] rdm(mdl_t m, logic [31:0] a, logic r);
    if (!r || !in_win(a)) return 32'h0;
    case (a[4:2])
      3'd0: return m.th;
      3'd1: return m.tl;
      3'd2: return {29'h0, m.tcon};
      3'd3: return {24'h0, m.led};
      3'd4: return {20'h0, m.digi};
      3'd5: return m.systick;
      default: return 32'h0;
    endcase
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  // Called just after a rising edge: drive, sample at the falling edge, then let the edge land.
  task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    addr = a; wd = d; we = w; re = r;
    @(negedge clk);
    c_rd1 = rd1; c_rd4 = rd4; c_hit = hit1; c_hit4 = hit4; c_irq1 = irq1; c_irq4 = irq4;
    c_led = led1; c_digi = digi1;
    e_rd1 = rdm(m1, a, r); e_rd4 = rdm(m4, a, r); e_hit = in_win(a);
    e_irq1 = m1.tcon[2] & m1.tcon[1]; e_irq4 = m4.tcon[2] & m4.tcon[1];
    e_led = m1.led; e_digi = m1.digi;
    @(posedge clk);
    m1 = step(m1, 1, a, d, w);
    m4 = step(m4, 4, a, d, w);
    #1;
    we = 0; re = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(32'h0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    we = 0; re = 0; reset = 0;
    m1 = '{default: '0};
    m4 = '{default: '0};
    repeat (3) @(posedge clk);
    #1 reset = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0]  = '{BASE + 32'h0C, 32'h0000_01A5, 1'b1, 1'b0, 32'h0, 1'b1};
    tbl[1]  = '{BASE + 32'h0C, 32'h0, 1'b0, 1'b1, 32'hA5, 1'b1};
    tbl[2]  = '{BASE + 32'h10, 32'hFFFF_F123, 1'b1, 1'b0, 32'h0, 1'b1};
    tbl[3]  = '{BASE + 32'h10, 32'h0, 1'b0, 1'b1, 32'h123, 1'b1};
    tbl[4]  = '{BASE + 32'h1C, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 1'b1};
    tbl[5]  = '{BASE + 32'h1C, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    tbl[6]  = '{BASE + 32'h20, 32'h55, 1'b1, 1'b1, 32'h0, 1'b0};
    tbl[7]  = '{32'h0000_000C, 32'h66, 1'b1, 1'b1, 32'h0, 1'b0};
    tbl[8]  = '{BASE + 32'h0D, 32'h0, 1'b0, 1'b1, 32'hA5, 1'b1};
    tbl[9]  = '{BASE + 32'h00, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    tbl[10] = '{BASE + 32'h08, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    tbl[11] = '{BASE + 32'h12, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[12] = '{BASE + 32'h14, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    tbl[13] = '{BASE + 32'h10, 32'h0, 1'b0, 1'b1, 32'h123, 1'b1};
    do_reset();
    chk("rst_led", {24'h0, led1}, 32'h0);
    chk("rst_digi", {20'h0, digi1}, 32'h0);
    chk("rst_irq", {31'h0, irq1}, 32'h0);
    chk("rst_rd", rd1, 32'h0);
    // Ten rising edges after release: SYSTICK sampled on the falling edge reads exactly 10.
    idle(10);
    apply(BASE + 32'h14, 32'h0, 1'b0, 1'b1);
    chk("systick10", c_rd1, 32'd10);
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].r);
      chk($sformatf("tbl%0d_rd", i), c_rd1, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_hit", i), {31'h0, c_hit}, {31'h0, tbl[i].exp_hit});
    end
    chk("led_out", {24'h0, led1}, 32'hA5);
    chk("digi_out", {20'h0, digi1}, 32'h123);
    apply(BASE + 32'h00, 32'hFFFF_FFF0, 1'b1, 1'b0);
    apply(BASE + 32'h04, 32'hFFFF_FFFE, 1'b1, 1'b0);
    apply(BASE + 32'h08, 32'h3, 1'b1, 1'b0);
    apply(BASE + 32'h04, 32'h0, 1'b0, 1'b1);
    chk("tl_fffe", c_rd1, 32'hFFFF_FFFE);
    apply(BASE + 32'h04, 32'h0, 1'b0, 1'b1);
    chk("tl_ffff", c_rd1, 32'hFFFF_FFFF);
    apply(BASE + 32'h04, 32'h0, 1'b0, 1'b1);
    chk("tl_reload", c_rd1, 32'hFFFF_FFF0);
    chk("irq_set", {31'h0, c_irq1}, 32'h1);
    apply(BASE + 32'h08, 32'h0, 1'b0, 1'b1);
    chk("tcon_7", c_rd1, 32'h7);
    apply(BASE + 32'h08, 32'h3, 1'b1, 1'b0);
    apply(BASE + 32'h08, 32'h0, 1'b0, 1'b1);
    chk("tcon_clr", c_rd1, 32'h3);
    chk("irq_clr", {31'h0, c_irq1}, 32'h0);
    apply(BASE + 32'h04, 32'hFFFF_FFFE, 1'b1, 1'b0);
    idle(1);
    apply(BASE + 32'h08, 32'h3, 1'b1, 1'b0);
    apply(BASE + 32'h08, 32'h0, 1'b0, 1'b1);
    chk("tcon_race", c_rd1, 32'h7);
    chk("irq_race", {31'h0, c_irq1}, 32'h1);
    do_reset();
    apply(BASE + 32'h04, 32'h0, 1'b1, 1'b0);
    apply(BASE + 32'h08, 32'h1, 1'b1, 1'b0);
    idle(4);
    apply(BASE + 32'h04, 32'h0, 1'b0, 1'b1);
    chk("ps4_tl1", c_rd4, 32'd1);
    idle(15);
    apply(BASE + 32'h04, 32'h0, 1'b0, 1'b1);
    chk("ps4_tl5", c_rd4, 32'd5);
    apply(BASE + 32'h08, 32'h0, 1'b1, 1'b0);
    idle(50);
    apply(BASE + 32'h04, 32'h0, 1'b0, 1'b1);
    chk("ps4_frozen", c_rd4, 32'd5);
    apply(BASE + 32'h04, 32'h100, 1'b1, 1'b0);
    apply(BASE + 32'h08, 32'h7, 1'b1, 1'b0);
    idle(3);
    chk("pre_rst_irq", {31'h0, irq1}, 32'h1);
    addr = BASE + 32'h04; re = 1;
    reset = 0;
    #2;
    chk("rst_tl", rd1, 32'h0);
    chk("rst_irq_mid", {31'h0, irq1}, 32'h0);
    addr = BASE + 32'h08;
    #1;
    chk("rst_tcon", rd1, 32'h0);
    do_reset();
    idle(10);
    apply(BASE + 32'h04, 32'h0, 1'b0, 1'b1);
    chk("tl_held", c_rd1, 32'h0);
    apply(BASE + 32'h08, 32'h1, 1'b1, 1'b0);
    idle(3);
    apply(BASE + 32'h04, 32'h0, 1'b0, 1'b1);
    chk("tl_resume", c_rd1, 32'd3);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      int sel;
      a = ($urandom_range(0, 9) == 9) ? $urandom : BASE + $urandom_range(0, 31);
      sel = $urandom_range(0, 3);
      d = sel == 0 ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : sel == 1 ? $urandom_range(0, 7) : $urandom;
      apply(a, d, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      chk("rnd_rd1", c_rd1, e_rd1);
      chk("rnd_rd4", c_rd4, e_rd4);
      chk("rnd_hit", {30'h0, c_hit, c_hit4}, {30'h0, e_hit, e_hit});
      chk("rnd_irq", {30'h0, c_irq1, c_irq4}, {30'h0, e_irq1, e_irq4});
      chk("rnd_led", {24'h0, c_led}, {24'h0, e_led});
      chk("rnd_digi", {20'h0, c_digi}, {20'h0, e_digi});
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
